// File: rtl/fifo_pkg.sv
// Purpose    : shared defaults and reset constants for the parametrised FIFO.
// Latency    : n/a (package only).
// Backpressure: n/a (package only).
// Contents: default DATA_W / DEPTH and the threshold values loaded at reset.
package fifo_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_DEPTH  = 8;

  // almost_full threshold comes out of reset one below DEPTH, almost_empty at 1.
  localparam int THR_HI_OFS = 1;
  localparam int THR_LO_RST = 1;

  function automatic int thr_hi_rst(input int depth);
    return depth - THR_HI_OFS;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Purpose    : FIFO storage, one write port and one registered read port.
// Latency    : read data appears on rd_dat one clock after rd_en.
// Backpressure: none; caller guarantees only legal reads/writes are enabled.
// Ports: clk, rst_n (clears read register only), wr_en/wr_addr/wr_dat,
//        rd_en/rd_addr, rd_dat (holds its value when rd_en=0).
module fifo_dpram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_dat_d;
  logic [DATA_W-1:0] rd_dat_q;

  // Array has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read-before-write: a same-address read and write in one cycle returns the
  // old word, which is what a full FIFO doing push+pop needs.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fifo_param.sv
// Purpose    : parametrised synchronous FIFO with programmable almost-full/empty thresholds.
// Latency    : popped word on data_out with valid_out=1 one clock after an accepted pop.
// Backpressure: push ignored while full unless a pop is accepted the same cycle; pop ignored while empty.
// Ports: clk, reset_L (async active-low), init (sync clear), cfg_load + umbral_superior/
//        umbral_inferior (thresholds), push/pop/data_in, data_out/valid_out, full/empty/
//        almost_full/almost_empty, fill_count, overflow/underflow.
// Build option: define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow; otherwise both read 0.
module fifo_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,     // power of two, >= 2
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  umbral_superior,
  input  logic [CNT_W-1:0]  umbral_inferior,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  fill_count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CNT_W-1:0] THR_HI_INIT = CNT_W'(thr_hi_rst(DEPTH));
  localparam logic [CNT_W-1:0] THR_LO_INIT = CNT_W'(THR_LO_RST);

  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [CNT_W-1:0]  thr_hi_d, thr_hi_q;
  logic [CNT_W-1:0]  thr_lo_d, thr_lo_q;
  logic              valid_d, valid_q;
  logic              push_acc, pop_acc;
  logic              full_w, empty_w;

  // Status is decoded from the occupancy counter, never from pointer compare,
  // so pointer wrap needs no extra bit.
  assign full_w  = (cnt_q == CNT_W'(DEPTH));
  assign empty_w = (cnt_q == '0);

  // init blocks both requests; a pop on a full FIFO frees the slot the push uses.
  assign pop_acc  = pop && !empty_w && !init;
  assign push_acc = push && (!full_w || (pop && !empty_w)) && !init;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    thr_hi_d = thr_hi_q;
    thr_lo_d = thr_lo_q;
    valid_d  = 1'b0;
    if (init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      valid_d = pop_acc;
      if (cfg_load) begin
        thr_hi_d = umbral_superior;
        thr_lo_d = umbral_inferior;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      thr_hi_q <= THR_HI_INIT;
      thr_lo_q <= THR_LO_INIT;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
      valid_q  <= valid_d;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dpram (
    .clk     (clk),
    .rst_n   (reset_L),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_q),
    .wr_dat  (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr_q),
    .rd_dat  (data_out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_d, ovf_q;
  logic udf_d, udf_q;

  // Sticky until reset or init. Overflow only counts a push that truly had
  // nowhere to go (full with no accepted pop).
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (init) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (push && full_w && !pop_acc) begin
        ovf_d = 1'b1;
      end
      if (pop && empty_w) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign valid_out    = valid_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (cnt_q >= thr_hi_q);
  assign almost_empty = (cnt_q <= thr_lo_q);
  assign fill_count   = cnt_q;

endmodule

// File: tb/tb_fifo_param.sv
// Purpose    : directed self-checking bench for fifo_param (DATA_W=10, DEPTH=8).
// Latency    : inputs driven 1ns after a rising edge, outputs sampled 1ns after the next.
// Backpressure: exercised via full/empty push and pop corner cases.
module tb_fifo_param;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic       cfg_load;
  logic [3:0] umbral_superior;
  logic [3:0] umbral_inferior;
  logic       push;
  logic       pop;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fill_count;
  logic       overflow;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_param #(.DATA_W(10), .DEPTH(8)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .cfg_load        (cfg_load),
    .umbral_superior (umbral_superior),
    .umbral_inferior (umbral_inferior),
    .push            (push),
    .pop             (pop),
    .data_in         (data_in),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .fill_count      (fill_count),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0; init = 1'b0; cfg_load = 1'b0;
    umbral_superior = '0; umbral_inferior = '0;
    push = 1'b0; pop = 1'b0; data_in = '0;

    // Reset state
    #12;
    chk("rst_empty",    32'(empty), 1);
    chk("rst_full",     32'(full), 0);
    chk("rst_aempty",   32'(almost_empty), 1);
    chk("rst_afull",    32'(almost_full), 0);
    chk("rst_count",    32'(fill_count), 0);
    chk("rst_valid",    32'(valid_out), 0);
    chk("rst_dout",     32'(data_out), 0);
    chk("rst_ovf",      32'(overflow), 0);
    chk("rst_udf",      32'(underflow), 0);
    tick();
    reset_L = 1'b1;

    // Fill with 1..8; default thr_hi=7
    push = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 10'(i);
      tick();
      chk("fill_count", 32'(fill_count), 32'(i));
      if (i == 7) begin
        chk("fill7_afull", 32'(almost_full), 1);
        chk("fill7_full",  32'(full), 0);
      end
    end
    chk("fill8_full",  32'(full), 1);
    chk("fill8_empty", 32'(empty), 0);
    data_in = 10'h155;
    tick();
    push = 1'b0;
    chk("push9_count", 32'(fill_count), 8);
    chk("push9_ovf",   32'(overflow), 32'(ERR));

    // Drain in order; rejected 0x155 must not appear
    pop = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("drain_dout",  32'(data_out), 32'(k));
      chk("drain_valid", 32'(valid_out), 1);
      chk("drain_count", 32'(fill_count), 32'(8 - k));
    end
    pop = 1'b0;
    tick();
    chk("idle_valid", 32'(valid_out), 0);
    chk("idle_hold",  32'(data_out), 8);
    chk("drain_empty", 32'(empty), 1);

    // Pop on empty
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("upop_valid", 32'(valid_out), 0);
    chk("upop_count", 32'(fill_count), 0);
    chk("upop_udf",   32'(underflow), 32'(ERR));
    chk("upop_hold",  32'(data_out), 8);
    tick();
    chk("udf_sticky", 32'(underflow), 32'(ERR));
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_udf", 32'(underflow), 0);
    chk("init_ovf", 32'(overflow), 0);

    // Thresholds 6 / 2
    cfg_load = 1'b1; umbral_superior = 4'd6; umbral_inferior = 4'd2;
    tick();
    cfg_load = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 10'(16 + i);
      tick();
      if (i == 1) chk("thr_ae_at2", 32'(almost_empty), 1);
      if (i == 2) chk("thr_ae_at3", 32'(almost_empty), 0);
      if (i == 4) chk("thr_af_at5", 32'(almost_full), 0);
    end
    push = 1'b0;
    chk("thr_af_at6", 32'(almost_full), 1);
    pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("thr_pop_dout", 32'(data_out), 32'(16 + k));
      if (k == 2) chk("thr_ae_at3d", 32'(almost_empty), 0);
    end
    pop = 1'b0;
    chk("thr_ae_at2d", 32'(almost_empty), 1);
    chk("thr_cnt2",    32'(fill_count), 2);

    // init beats push, pop and cfg_load
    init = 1'b1; push = 1'b1; pop = 1'b1; data_in = 10'h1EE;
    cfg_load = 1'b1; umbral_superior = 4'd0; umbral_inferior = 4'd0;
    tick();
    init = 1'b0; push = 1'b0; pop = 1'b0; cfg_load = 1'b0;
    chk("initp_count", 32'(fill_count), 0);
    chk("initp_empty", 32'(empty), 1);
    chk("initp_valid", 32'(valid_out), 0);
    chk("initp_afull", 32'(almost_full), 0);
    chk("initp_hold",  32'(data_out), 32'h13);

    // Full with simultaneous push/pop
    cfg_load = 1'b1; umbral_superior = 4'd5; umbral_inferior = 4'd3;
    tick();
    cfg_load = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 10'(32 + i);
      tick();
    end
    chk("pp_full",  32'(full), 1);
    pop = 1'b1; data_in = 10'h3FF;
    tick();
    push = 1'b0;
    chk("pp_count", 32'(fill_count), 8);
    chk("pp_dout",  32'(data_out), 32'h20);
    chk("pp_valid", 32'(valid_out), 1);
    chk("pp_ovf",   32'(overflow), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("pp_drain", 32'(data_out), (k == 8) ? 32'h3FF : 32'(32 + k));
    end
    pop = 1'b0;
    chk("pp_empty", 32'(empty), 1);

    // Wrap: push 5 / pop 5 three times
    for (int r = 0; r < 3; r++) begin
      push = 1'b1;
      for (int i = 0; i < 5; i++) begin
        data_in = 10'(64 + r * 8 + i);
        tick();
      end
      push = 1'b0; pop = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("wrap_dout", 32'(data_out), 32'(64 + r * 8 + i));
      end
      pop = 1'b0;
    end
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 10'(112 + i);
      tick();
    end
    chk("mid_count", 32'(fill_count), 3);

    // Asynchronous reset mid-stream
    pop = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    chk("arst_count",  32'(fill_count), 0);
    chk("arst_empty",  32'(empty), 1);
    chk("arst_full",   32'(full), 0);
    chk("arst_aempty", 32'(almost_empty), 1);
    chk("arst_afull",  32'(almost_full), 0);
    chk("arst_valid",  32'(valid_out), 0);
    chk("arst_dout",   32'(data_out), 0);
    tick();
    reset_L = 1'b1;

    // First cycle after release: push+pop on empty, only push accepted
    push = 1'b1; pop = 1'b1; data_in = 10'h0A0;
    tick();
    pop = 1'b0;
    chk("post_count", 32'(fill_count), 1);
    chk("post_valid", 32'(valid_out), 0);
    for (int i = 1; i <= 4; i++) begin
      data_in = 10'(160 + i);
      tick();
      if (i == 1) chk("post_aempty2", 32'(almost_empty), 0);
    end
    push = 1'b0;
    chk("post_afull5", 32'(almost_full), 0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("post_dout",  32'(data_out), 32'h0A0);
    chk("post_dvld",  32'(valid_out), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 10, width of each stored word.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, minimum 2.
REQ-003 Derived constant ADDR_W = log2(DEPTH); CNT_W = ADDR_W+1.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 init  input  1  synchronous clear of pointers, count and flags; stored data unaffected.
REQ-007 cfg_load  input  1  capture both thresholds this cycle.
REQ-008 umbral_superior  input  CNT_W  almost-full threshold value.
REQ-009 umbral_inferior  input  CNT_W  almost-empty threshold value.
REQ-010 push / pop  input  1 each  write / read requests.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 data_out  output  DATA_W  registered read data.
REQ-013 valid_out  output  1  data_out holds a word popped on the previous cycle.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 fill_count  output  CNT_W  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags (REQ-034).

Function
REQ-017 Push SHALL be accepted when push=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-018 Pop SHALL be accepted when pop=1 and empty=0.
REQ-019 Accepted push writes data_in at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-020 Accepted pop reads at rd_ptr, rd_ptr increments modulo DEPTH; data_out and valid_out=1 appear one cycle later.
REQ-021 Without an accepted pop, valid_out SHALL be 0 next cycle and data_out SHALL hold its last value.
REQ-022 fill_count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 Simultaneous push and pop on empty: only push accepted; on full: both accepted, count stays DEPTH.
REQ-024 full = (fill_count == DEPTH); empty = (fill_count == 0); both decoded from registered count.
REQ-025 almost_full = (fill_count >= thr_hi); almost_empty = (fill_count <= thr_lo); thr_hi/thr_lo are internal registers loaded on cfg_load.
REQ-026 Rejected push or pop SHALL change no pointer, count or memory location.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; full/empty are never decided by pointer compare.
REQ-028 init SHALL take priority over push, pop and cfg_load in the same cycle.

Reset
REQ-029 reset_L=0 SHALL immediately clear wr_ptr, rd_ptr, fill_count, valid_out, data_out, overflow, underflow.
REQ-030 During reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-031 Reset SHALL set thr_hi=DEPTH-1 and thr_lo=1.
REQ-032 Reset mid-operation discards all contents; first cycle after release behaves as empty.

Configuration
REQ-033 Macro FIFO_ERR_FLAGS_EN selects error reporting.
REQ-034 With it: overflow sets on push while full with no pop, underflow sets on pop while empty; both stay set until reset_L or init.
REQ-035 Without it: overflow and underflow SHALL be tied to 0; all other behaviour identical.

Structure
REQ-036 Shared package fifo_pkg SHALL hold default DATA_W, DEPTH and reset threshold constants.
REQ-037 Storage SHALL be sub-module fifo_dpram: one write port, one registered read port, parametrised DATA_W/ADDR_W, no reset on array.

Verification
REQ-038 Reset, push 8 words 0x001..0x008 -> full=1, fill_count=8; 9th push rejected (overflow=1 with macro).
REQ-039 Pop 8 times -> data_out 0x001..0x008 in order, each with valid_out=1 one cycle after pop; empty=1 at end.
REQ-040 cfg_load thr_hi=6, thr_lo=2; push 6 -> almost_full=1 at count 6; pop to 2 -> almost_empty=1.
REQ-041 Full FIFO, push=pop=1 with 0x3FF -> count stays 8, oldest word out, 0x3FF later read last.
REQ-042 Pop on empty -> no pointer change, valid_out=0, underflow=1 (macro) else 0.
REQ-043 Push 5, pop 5 three times (wrap) then reset_L pulse mid-stream -> count=0, flags per REQ-030.
